// File: rtl/fm_i2s_tx.sv
// I2S (Philips) master transmitter: FIFO-buffered mono samples sent in both slots of each frame.
// All outputs registered; a sample arriving with the FIFO full and no pop is dropped and flagged.
module fm_i2s_tx #(
  parameter int CLK_DIV    = 16,
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [SAMPLE_W-1:0]  sample,
  input  logic                        sample_valid,
  input  logic                        clr_flags,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underrun
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(2 * SLOT_W);
  localparam int POS_W  = $clog2(SLOT_W);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int SIDX_W = $clog2(SAMPLE_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic [SAMPLE_W-1:0] word_q, word_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic                ovf_q, ovf_d;
  logic                und_q, und_d;
  logic                en_q;

  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

  logic                fall;
  logic                frame_start;
  logic                pop;
  logic                push;
  logic [POS_W-1:0]    pos;
  logic [SIDX_W-1:0]   idx;

  always_comb begin
    div_d       = div_q;
    bclk_d      = bclk_q;
    bit_d       = bit_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    word_d      = word_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    lvl_d       = lvl_q;
    ovf_d       = ovf_q;
    und_d       = und_q;
    fall        = 1'b0;
    frame_start = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    pos         = '0;
    idx         = '0;

    // Set events below override this clear, so a same-cycle set wins.
    if (clr_flags) begin
      ovf_d = 1'b0;
      und_d = 1'b0;
    end

    if (!enable) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      bit_d   = '0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      word_d  = '0;
      rd_d    = '0;
      wr_d    = '0;
      lvl_d   = '0;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
        fall   = bclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end

      if (fall) begin
        bit_d = bit_q + 1'b1;
        frame_start = (bit_q == '1);
      end
      if (!en_q) frame_start = 1'b1;
      lrclk_d = bit_d[BIT_W-1];

      if (frame_start) begin
        if (lvl_q != '0) begin
          pop    = 1'b1;
          word_d = mem_q[rd_q];
          rd_d   = rd_q + 1'b1;
        end else begin
          word_d = '0;
          und_d  = 1'b1;
        end
      end

      if (sample_valid) begin
        if (lvl_q != LVL_FULL || pop) begin
          push = 1'b1;
          wr_d = wr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      lvl_d = lvl_q + LVL_W'(push) - LVL_W'(pop);

      // Slot position 0 is the one-BCLK I2S delay; the word follows MSB first.
      if (fall) begin
        pos     = bit_d[POS_W-1:0];
        sdata_d = 1'b0;
        if (pos != '0 && int'(pos) <= SAMPLE_W) begin
          idx     = SIDX_W'(SAMPLE_W - int'(pos));
          sdata_d = word_d[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      bit_q   <= '0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      word_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      bit_q   <= bit_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      word_q  <= word_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
      en_q    <= enable;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= sample;
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = lvl_q;
  assign overflow   = ovf_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_fm_i2s_tx.sv
// Bench for fm_i2s_tx: table vectors, hand-written frame sequences and randomized traffic
// checked every cycle against a closed-form timing model with a queue-based FIFO.
module tb_fm_i2s_tx;

  localparam int CLK_DIV    = 2;
  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_CYC  = 2 * CLK_DIV * 2 * SLOT_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        clr_flags = 1'b0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun;
  logic [2:0]  fifo_level;

  fm_i2s_tx #(
    .CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample),
    .sample_valid(sample_valid), .clr_flags(clr_flags),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .fifo_level(fifo_level), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model: n counts enabled edges starting at 1.
  bit          m_on = 1'b0;
  int          m_n = 0;
  bit          m_fs = 1'b0;
  logic [15:0] m_q[$];
  logic [15:0] m_word = '0;
  bit          m_ovf = 1'b0;
  bit          m_und = 1'b0;

  logic        prev_bclk = 1'b0;
  logic        sd_log[$];
  logic        lr_log[$];

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        sv;
    logic [15:0] smp;
    logic        clr;
    int          reps;
    logic [7:0]  exp;
  } vec_t;

  vec_t vec[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_edge();
    bit ovf_ev, und_ev;
    ovf_ev = 1'b0;
    und_ev = 1'b0;
    m_fs   = 1'b0;
    if (rst) begin
      m_on = 1'b0; m_n = 0; m_q.delete(); m_word = '0; m_ovf = 1'b0; m_und = 1'b0;
    end else if (!enable) begin
      m_on = 1'b0; m_n = 0; m_q.delete(); m_word = '0;
      if (clr_flags) begin m_ovf = 1'b0; m_und = 1'b0; end
    end else begin
      if (!m_on) begin m_on = 1'b1; m_n = 1; end
      else m_n++;
      m_fs = (m_n == 1) || (m_n % FRAME_CYC == 0);
      if (m_fs) begin
        if (m_q.size() > 0) m_word = m_q.pop_front();
        else begin m_word = '0; und_ev = 1'b1; end
      end
      if (sample_valid) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(sample);
        else ovf_ev = 1'b1;
      end
      if (clr_flags) begin m_ovf = 1'b0; m_und = 1'b0; end
      m_ovf = m_ovf | ovf_ev;
      m_und = m_und | und_ev;
    end
  endtask

  function automatic logic [7:0] model_out();
    int b, p;
    logic bc, lr, sd;
    bc = 1'b0; lr = 1'b0; sd = 1'b0;
    if (m_on) begin
      bc = ((m_n / CLK_DIV) % 2) == 1;
      b  = (m_n / (2 * CLK_DIV)) % (2 * SLOT_W);
      lr = (b >= SLOT_W);
      p  = b % SLOT_W;
      if (p >= 1 && p <= SAMPLE_W) sd = m_word[4'(SAMPLE_W - p)];
    end
    return {bc, lr, sd, 3'(m_q.size()), m_ovf, m_und};
  endfunction

  function automatic logic [7:0] dut_out();
    return {i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underrun};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check($sformatf("cycle%0d", cyc), 64'(dut_out()), 64'(model_out()));
    if (!prev_bclk && i2s_bclk) begin
      sd_log.push_back(i2s_sdata);
      lr_log.push_back(i2s_lrclk);
    end
    prev_bclk = i2s_bclk;
  endtask

  task automatic wait_rises(input string name, input int n);
    for (int k = 0; k < (4 * CLK_DIV * n + 64) && sd_log.size() < n; k++) tick();
    check(name, 64'(sd_log.size()), 64'(n));
  endtask

  task automatic run_to_fs();
    for (int k = 0; k < FRAME_CYC + 8; k++) begin
      tick();
      if (m_fs) break;
    end
  endtask

  task automatic run_to_before_fs();
    for (int k = 0; k < FRAME_CYC + 8 && ((m_n + 1) % FRAME_CYC) != 0; k++) tick();
  endtask

  function automatic logic [63:0] log_frame(input int f, input bit want_lr);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 2 * SLOT_W; i++)
      if (f * 64 + i < sd_log.size())
        v[6'(i)] = want_lr ? lr_log[f * 64 + i] : sd_log[f * 64 + i];
    return v;
  endfunction

  function automatic logic [63:0] exp_frame(input logic [15:0] w);
    logic [63:0] v;
    int p;
    v = '0;
    for (int i = 0; i < 2 * SLOT_W; i++) begin
      p = i % SLOT_W;
      if (p >= 1 && p <= SAMPLE_W) v[6'(i)] = w[4'(SAMPLE_W - p)];
    end
    return v;
  endfunction

  localparam logic [63:0] LR_PATTERN = 64'hFFFF_FFFF_0000_0000;

  int rate;

  initial begin
    vec[0] = '{"reset",    1'b1, 1'b1, 1'b1, 16'h8001, 1'b0, 5, 8'h00};
    vec[1] = '{"dis_push", 1'b0, 1'b0, 1'b1, 16'h8001, 1'b0, 1, 8'h00};
    vec[2] = '{"dis_idle", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3, 8'h00};
    vec[3] = '{"en_first", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1, 8'h01};
    vec[4] = '{"en_rise",  1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1, 8'h81};
    vec[5] = '{"push8001", 1'b0, 1'b1, 1'b1, 16'h8001, 1'b0, 1, 8'h85};
    vec[6] = '{"first_fall", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1, 8'h05};

    for (int i = 0; i < 7; i++) begin
      rst = vec[i].rst; enable = vec[i].en; sample_valid = vec[i].sv;
      sample = vec[i].smp; clr_flags = vec[i].clr;
      repeat (vec[i].reps) tick();
      check(vec[i].name, 64'(dut_out()), 64'(vec[i].exp));
    end
    sample_valid = 1'b0;

    // Underrun frame, then the 0x8001 frame in both slots.
    wait_rises("t2_rises", 128);
    check("t2_frame0", log_frame(0, 1'b0), 64'h0);
    check("t2_frame1", log_frame(1, 1'b0), 64'h0001_0002_0001_0002);
    check("t2_lrclk",  log_frame(1, 1'b1), LR_PATTERN);

    // Five back-to-back pushes into a four-entry FIFO.
    run_to_fs();
    sd_log.delete(); lr_log.delete();
    for (int s = 1; s <= 5; s++) begin
      sample_valid = 1'b1; sample = 16'(s);
      tick();
    end
    sample_valid = 1'b0;
    check("t3_level", 64'(fifo_level), 64'd4);
    check("t3_ovf", 64'(overflow), 64'd1);
    wait_rises("t3_rises", 320);
    check("t3_frame0", log_frame(0, 1'b0), 64'h0);
    for (int f = 1; f <= 4; f++)
      check($sformatf("t3_frame%0d", f), log_frame(f, 1'b0), exp_frame(16'(f)));

    // Full FIFO: a push in the frame-start cycle is accepted.
    run_to_fs();
    for (int s = 0; s < 4; s++) begin
      sample_valid = 1'b1; sample = 16'h000A + 16'(s);
      tick();
    end
    sample_valid = 1'b0;
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("t4_full", 64'({fifo_level, overflow}), 64'({3'd4, 1'b0}));
    run_to_before_fs();
    sample_valid = 1'b1; sample = 16'h000E;
    tick();
    sample_valid = 1'b0;
    check("t4_fs_push", 64'({fifo_level, overflow, underrun}), 64'({3'd4, 1'b0, 1'b0}));

    // Underrun, clear, then clear colliding with an underrun frame start.
    enable = 1'b0; tick();
    check("t5_flush", 64'(fifo_level), 64'd0);
    enable = 1'b1; tick();
    check("t5_und_set", 64'(underrun), 64'd1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("t5_und_clr", 64'(underrun), 64'd0);
    run_to_before_fs();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("t5_set_wins", 64'(underrun), 64'd1);

    // Drop enable mid-frame, then restart.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    sample_valid = 1'b1; sample = 16'h1111; tick();
    sample = 16'h2222; tick();
    sample_valid = 1'b0;
    for (int k = 0; k < FRAME_CYC + 8 && ((m_n / (2 * CLK_DIV)) % (2 * SLOT_W)) != 20; k++) tick();
    check("t6_level", 64'(fifo_level), 64'd2);
    enable = 1'b0; tick();
    check("t6_drop", 64'({i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level}), 64'd0);
    sd_log.delete(); lr_log.delete();
    enable = 1'b1; tick();
    check("t6_restart", 64'({i2s_bclk, underrun}), 64'({1'b0, 1'b1}));
    tick();
    check("t6_bclk_rise", 64'(i2s_bclk), 64'd1);
    wait_rises("t6_rises", 64);
    check("t6_frame", log_frame(0, 1'b0), 64'h0);
    check("t6_lrclk", log_frame(0, 1'b1), LR_PATTERN);

    // Randomized traffic against the model.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    rate = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 512 == 0) rate = int'($urandom_range(0, 12));
      if (enable && $urandom_range(0, 999) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      sample_valid = (int'($urandom_range(0, 999)) < rate);
      sample       = 16'($urandom);
      clr_flags    = enable && ($urandom_range(0, 399) == 0);
      tick();
    end
    sample_valid = 1'b0;
    clr_flags = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
